vfu_seq_ctrl: RTL

VFU_SEQ_CTRL -- requirements
Module: vfu_seq_ctrl

---
 rtl/vfu_seq_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/vfu_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// vfu_seq_ctrl : vector element sequencer for a fixed-latency pipelined operator
// Revision     : 1.0
// ============================================================================
module vfu_seq_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int MVL        = 32,
  parameter int LAT        = 4,
  parameter int ID         = 0,
  localparam int VLW       = $clog2(MVL) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [VLW-1:0]        vlr_i,
  input  logic [MVL-1:0]        mask_i,
  input  logic [1:0]            esc_sel_i,
  input  logic [DATA_WIDTH:0]   op_esc_i,
  input  logic [DATA_WIDTH:0]   operand_a_i,
  input  logic [DATA_WIDTH:0]   operand_b_i,
  output logic [DATA_WIDTH-1:0] fu_a_o,
  output logic [DATA_WIDTH-1:0] fu_b_o,
  output logic                  fu_valid_o,
  input  logic [DATA_WIDTH-1:0] fu_result_i,
  output logic [DATA_WIDTH+1:0] out_o,
  output logic [VLW-1:0]        out_idx_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [VLW-1:0] C_MVL = VLW'(MVL);
  localparam logic [VLW-1:0] C_ONE = VLW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [VLW-1:0]      vlr_q, vlr_d;
  logic [MVL-1:0]      mask_q, mask_d;
  logic [1:0]          esc_sel_q, esc_sel_d;
  logic [DATA_WIDTH:0] esc_q, esc_d;
  logic [VLW-1:0]      issue_cnt_q, issue_cnt_d;
  logic [VLW-1:0]      done_cnt_q, done_cnt_d;
  logic                zdone_q, zdone_d;

  // Tag pipeline mirrors the operator: stage LAT-1 lines up with fu_result_i.
  logic                tag_v_q   [LAT];
  logic                tag_m_q   [LAT];
  logic [VLW-1:0]      tag_idx_q [LAT];

  logic [DATA_WIDTH:0]   w_eff_a;
  logic [DATA_WIDTH:0]   w_eff_b;
  logic [MVL-1:0]        w_mask_sh;
  logic                  w_mask_bit;
  logic                  w_issue;
  logic                  w_tail_v;
  logic                  w_tail_m;
  logic [VLW-1:0]        w_tail_idx;
  logic [VLW-1:0]        w_vlr_m1;
  logic                  w_last_out;
  logic [DATA_WIDTH-1:0] w_out_data;
  logic [31:0]           w_unused_id;

  assign w_unused_id = ID;

  assign w_eff_a = (esc_sel_q == 2'b10) ? esc_q : operand_a_i;
  assign w_eff_b = (esc_sel_q == 2'b11) ? esc_q : operand_b_i;
  assign fu_a_o  = w_eff_a[DATA_WIDTH-1:0];
  assign fu_b_o  = w_eff_b[DATA_WIDTH-1:0];

  assign w_mask_sh  = mask_q >> issue_cnt_q;
  assign w_mask_bit = w_mask_sh[0];

  // An invalid captured scalar keeps its valid bit low, so issue stalls forever.
  assign w_issue = (state_q == S_ISSUE) && w_eff_a[DATA_WIDTH] && w_eff_b[DATA_WIDTH]
                   && (issue_cnt_q < vlr_q);
  assign fu_valid_o = w_issue & w_mask_bit;

  assign w_tail_v   = tag_v_q[LAT-1];
  assign w_tail_m   = tag_m_q[LAT-1];
  assign w_tail_idx = tag_idx_q[LAT-1];
  assign w_vlr_m1   = vlr_q - C_ONE;
  assign w_out_data = w_tail_m ? fu_result_i : {DATA_WIDTH{1'b0}};

  assign out_o     = w_tail_v ? {1'b1, w_tail_m, w_out_data} : {(DATA_WIDTH+2){1'b0}};
  assign out_idx_o = w_tail_v ? w_tail_idx : {VLW{1'b0}};

  assign w_last_out = w_tail_v && (state_q != S_IDLE) && (w_tail_idx == w_vlr_m1);
  assign done_o     = w_last_out | zdone_q;
  assign busy_o     = (state_q != S_IDLE);

  always_comb begin
    state_d     = state_q;
    vlr_d       = vlr_q;
    mask_d      = mask_q;
    esc_sel_d   = esc_sel_q;
    esc_d       = esc_q;
    issue_cnt_d = issue_cnt_q;
    done_cnt_d  = done_cnt_q;
    zdone_d     = 1'b0;

    if (w_issue) begin
      issue_cnt_d = issue_cnt_q + C_ONE;
    end
    if (w_tail_v && (done_cnt_q < vlr_q)) begin
      done_cnt_d = done_cnt_q + C_ONE;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (vlr_i == {VLW{1'b0}}) begin
            zdone_d = 1'b1;
          end else begin
            vlr_d       = (vlr_i > C_MVL) ? C_MVL : vlr_i;
            mask_d      = mask_i;
            esc_sel_d   = esc_sel_i;
            esc_d       = op_esc_i;
            issue_cnt_d = {VLW{1'b0}};
            done_cnt_d  = {VLW{1'b0}};
            state_d     = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (w_issue && (issue_cnt_q == w_vlr_m1)) begin
          state_d = S_DRAIN;
        end
        if (w_last_out) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (w_last_out) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      vlr_q       <= {VLW{1'b0}};
      mask_q      <= {MVL{1'b0}};
      esc_sel_q   <= 2'b00;
      esc_q       <= {(DATA_WIDTH+1){1'b0}};
      issue_cnt_q <= {VLW{1'b0}};
      done_cnt_q  <= {VLW{1'b0}};
      zdone_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      vlr_q       <= vlr_d;
      mask_q      <= mask_d;
      esc_sel_q   <= esc_sel_d;
      esc_q       <= esc_d;
      issue_cnt_q <= issue_cnt_d;
      done_cnt_q  <= done_cnt_d;
      zdone_q     <= zdone_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) begin
        tag_v_q[i]   <= 1'b0;
        tag_m_q[i]   <= 1'b0;
        tag_idx_q[i] <= {VLW{1'b0}};
      end
    end else begin
      tag_v_q[0]   <= w_issue;
      tag_m_q[0]   <= w_mask_bit;
      tag_idx_q[0] <= issue_cnt_q;
      for (int i = 1; i < LAT; i++) begin
        tag_v_q[i]   <= tag_v_q[i-1];
        tag_m_q[i]   <= tag_m_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
    end
  end

endmodule
`default_nettype wire
